// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared ID/EX encodings, FSM state and the bubble constant.
package mips_pipe_pkg;

    localparam logic [1:0] SEL_SHAMT_IMM = 2'b00;
    localparam logic [1:0] SEL_MEM       = 2'b01;
    localparam logic [1:0] SEL_EX        = 2'b10;
    localparam logic [1:0] SEL_REG       = 2'b11;

    typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        use_shamt;
        logic        use_immed;
        logic [3:0]  alu_ctrl;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  alu_op_a;
        logic [1:0]  alu_op_b;
        logic        dmf_ex;
        logic        dmf_mem;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{alu_op_a: SEL_REG, alu_op_b: SEL_REG, default: '0};

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs and execute-side outputs of the ID/EX register.
interface id_ex_pipe_reg_if;

    logic        Flush;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rw;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, UseShamt, UseImmed;
    logic [3:0]  ID_ALUCtrl;
    logic [31:0] ID_BusA, ID_BusB, ID_Imm;
    logic [4:0]  ID_Shamt;
    logic [1:0]  AluOpCtrlA, AluOpCtrlB;
    logic        DataMemForwardCtrl_EX, DataMemForwardCtrl_MEM;
    logic        Stall;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rw;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_UseShamt, EX_UseImmed;
    logic [3:0]  EX_ALUCtrl;
    logic [31:0] EX_BusA, EX_BusB, EX_Imm;
    logic [4:0]  EX_Shamt;
    logic [1:0]  EX_AluOpCtrlA, EX_AluOpCtrlB;
    logic        EX_DataMemForwardCtrl_EX, EX_DataMemForwardCtrl_MEM;
    logic [31:0] StallCount, FlushCount;

    modport master (
        output Flush, ID_Rs, ID_Rt, ID_Rw, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
               UseShamt, UseImmed, ID_ALUCtrl, ID_BusA, ID_BusB, ID_Imm, ID_Shamt,
               AluOpCtrlA, AluOpCtrlB, DataMemForwardCtrl_EX, DataMemForwardCtrl_MEM,
        input  Stall, EX_Rs, EX_Rt, EX_Rw, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
               EX_UseShamt, EX_UseImmed, EX_ALUCtrl, EX_BusA, EX_BusB, EX_Imm, EX_Shamt,
               EX_AluOpCtrlA, EX_AluOpCtrlB, EX_DataMemForwardCtrl_EX, EX_DataMemForwardCtrl_MEM,
               StallCount, FlushCount
    );

    modport slave (
        input  Flush, ID_Rs, ID_Rt, ID_Rw, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
               UseShamt, UseImmed, ID_ALUCtrl, ID_BusA, ID_BusB, ID_Imm, ID_Shamt,
               AluOpCtrlA, AluOpCtrlB, DataMemForwardCtrl_EX, DataMemForwardCtrl_MEM,
        output Stall, EX_Rs, EX_Rt, EX_Rw, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
               EX_UseShamt, EX_UseImmed, EX_ALUCtrl, EX_BusA, EX_BusB, EX_Imm, EX_Shamt,
               EX_AluOpCtrlA, EX_AluOpCtrlB, EX_DataMemForwardCtrl_EX, EX_DataMemForwardCtrl_MEM,
               StallCount, FlushCount
    );

endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds an ALU operand of the ID instruction.
module load_use_detect (
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       use_shamt_i,
    input  logic       use_immed_i,
    input  logic [4:0] ex_rw_i,
    input  logic       ex_mem_read_i,
    output logic       hazard_o
);

    // Store data through Rt is not an ALU operand; the MEM forwarding path covers it.
    assign hazard_o = ex_mem_read_i && (ex_rw_i != 5'd0) &&
                      ((!use_shamt_i && id_rs_i == ex_rw_i) || (!use_immed_i && id_rt_i == ex_rw_i));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with load-use bubble insertion and flush.
// Define ID_EX_PERF_CNT_EN to build the saturating stall/flush event counters.
module id_ex_pipe_reg
    import mips_pipe_pkg::*;
(
    input logic CLK,
    input logic Reset,
    id_ex_pipe_reg_if.slave bus
);

    id_ex_t id_s, ex_d, ex_q;
    state_t state_q;
    logic   hazard;

    assign id_s = {bus.ID_Rs, bus.ID_Rt, bus.ID_Rw, bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite,
                   bus.ID_MemToReg, bus.UseShamt, bus.UseImmed, bus.ID_ALUCtrl, bus.ID_BusA,
                   bus.ID_BusB, bus.ID_Imm, bus.ID_Shamt, bus.AluOpCtrlA, bus.AluOpCtrlB,
                   bus.DataMemForwardCtrl_EX, bus.DataMemForwardCtrl_MEM};

    load_use_detect u_lud (
        .id_rs_i       (bus.ID_Rs),
        .id_rt_i       (bus.ID_Rt),
        .use_shamt_i   (bus.UseShamt),
        .use_immed_i   (bus.UseImmed),
        .ex_rw_i       (ex_q.rw),
        .ex_mem_read_i (ex_q.mem_read),
        .hazard_o      (hazard)
    );

    // Reset suppresses the stall so upstream never sees one during reset.
    assign bus.Stall = hazard && !bus.Flush && !Reset && state_q == ST_RUN;
    assign ex_d      = (bus.Flush || hazard) ? ID_EX_BUBBLE : id_s;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ex_q    <= ID_EX_BUBBLE;
            state_q <= ST_RUN;
        end else begin
            ex_q    <= ex_d;
            state_q <= bus.Stall ? ST_BUBBLE : ST_RUN;
        end
    end

    assign {bus.EX_Rs, bus.EX_Rt, bus.EX_Rw, bus.EX_RegWrite, bus.EX_MemRead, bus.EX_MemWrite,
            bus.EX_MemToReg, bus.EX_UseShamt, bus.EX_UseImmed, bus.EX_ALUCtrl, bus.EX_BusA,
            bus.EX_BusB, bus.EX_Imm, bus.EX_Shamt, bus.EX_AluOpCtrlA, bus.EX_AluOpCtrlB,
            bus.EX_DataMemForwardCtrl_EX, bus.EX_DataMemForwardCtrl_MEM} = ex_q;

    // A bubble clears EX_MemRead, so a load can never stall twice in a row.
    a_one_stall: assert property (@(posedge CLK) disable iff (Reset) state_q == ST_BUBBLE |-> !hazard);

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.Stall && ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.Flush && ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.StallCount = stall_cnt_q;
    assign bus.FlushCount = flush_cnt_q;
`else
    assign bus.StallCount = '0;
    assign bus.FlushCount = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench for the ID/EX register with directed hazard/flush vectors.
module tb_id_ex_pipe_reg;
    import mips_pipe_pkg::*;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    id_ex_pipe_reg_if bus ();

    id_ex_pipe_reg dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        id_ex_t      ex;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_sc = '0;
    logic [31:0] exp_fc = '0;

    function automatic id_ex_t ins(input logic [4:0] rs, rt, rw, input logic mr, mw, us, ui, dm,
                                   input logic [1:0] sa);
        id_ex_t v;
        v           = '0;
        v.rs        = rs;
        v.rt        = rt;
        v.rw        = rw;
        v.reg_write = !mw;
        v.mem_read  = mr;
        v.mem_write = mw;
        v.mem_to_reg= mr;
        v.use_shamt = us;
        v.use_immed = ui;
        v.alu_ctrl  = {1'b1, us, mr, mw};
        v.bus_a     = 32'hA000_0000 | {27'd0, rs};
        v.bus_b     = 32'hB000_0000 | {27'd0, rt};
        v.imm       = 32'h0000_FF00 | {27'd0, rw};
        v.shamt     = rs ^ rt;
        v.alu_op_a  = sa;
        v.alu_op_b  = ui ? SEL_SHAMT_IMM : SEL_REG;
        v.dmf_ex    = mw & ~dm;
        v.dmf_mem   = dm;
        return v;
    endfunction

    // One cycle of stimulus; st/cap are the hand-derived stall and capture outcomes.
    task automatic step(input id_ex_t v, input logic rst, fl, st, cap);
        exp_t e;
        @(posedge CLK);
        #2;
        Reset     = rst;
        bus.Flush = fl;
        {bus.ID_Rs, bus.ID_Rt, bus.ID_Rw, bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite,
         bus.ID_MemToReg, bus.UseShamt, bus.UseImmed, bus.ID_ALUCtrl, bus.ID_BusA, bus.ID_BusB,
         bus.ID_Imm, bus.ID_Shamt, bus.AluOpCtrlA, bus.AluOpCtrlB, bus.DataMemForwardCtrl_EX,
         bus.DataMemForwardCtrl_MEM} = v;
`ifdef ID_EX_PERF_CNT_EN
        if (rst) begin
            exp_sc = '0;
            exp_fc = '0;
        end else begin
            if (st && exp_sc != '1) exp_sc = exp_sc + 32'd1;
            if (fl && exp_fc != '1) exp_fc = exp_fc + 32'd1;
        end
`endif
        e.stall = st;
        e.ex    = cap ? v : ID_EX_BUBBLE;
        e.sc    = exp_sc;
        e.fc    = exp_fc;
        q.push_back(e);
    endtask

    initial begin
        exp_t   e;
        logic   s;
        id_ex_t act;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e = q.pop_front();
                s = bus.Stall;
                @(posedge CLK);
                #1;
                act = {bus.EX_Rs, bus.EX_Rt, bus.EX_Rw, bus.EX_RegWrite, bus.EX_MemRead,
                       bus.EX_MemWrite, bus.EX_MemToReg, bus.EX_UseShamt, bus.EX_UseImmed,
                       bus.EX_ALUCtrl, bus.EX_BusA, bus.EX_BusB, bus.EX_Imm, bus.EX_Shamt,
                       bus.EX_AluOpCtrlA, bus.EX_AluOpCtrlB, bus.EX_DataMemForwardCtrl_EX,
                       bus.EX_DataMemForwardCtrl_MEM};
                total = total + 4;
                if (s !== e.stall) begin
                    bad++;
                    $display("FAIL stall t=%0t got=%b want=%b", $time, s, e.stall);
                end
                if (act !== e.ex) begin
                    bad++;
                    $display("FAIL ex_regs t=%0t got=%h want=%h", $time, act, e.ex);
                end
                if (bus.StallCount !== e.sc) begin
                    bad++;
                    $display("FAIL stall_count t=%0t got=%h want=%h", $time, bus.StallCount, e.sc);
                end
                if (bus.FlushCount !== e.fc) begin
                    bad++;
                    $display("FAIL flush_count t=%0t got=%h want=%h", $time, bus.FlushCount, e.fc);
                end
            end
        end
    end

    initial begin
        logic [159:0] r;
        id_ex_t lw5, lw9, add5, add5f;
        lw5   = ins(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SEL_REG);
        lw9   = ins(5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SEL_REG);
        add5  = ins(5'd5, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_EX);
        add5f = ins(5'd5, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_MEM);
        bus.Flush = 1'b0;
        {bus.ID_Rs, bus.ID_Rt, bus.ID_Rw, bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite,
         bus.ID_MemToReg, bus.UseShamt, bus.UseImmed, bus.ID_ALUCtrl, bus.ID_BusA, bus.ID_BusB,
         bus.ID_Imm, bus.ID_Shamt, bus.AluOpCtrlA, bus.AluOpCtrlB, bus.DataMemForwardCtrl_EX,
         bus.DataMemForwardCtrl_MEM} = '0;
        for (int i = 0; i < 2; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step(r[131:0], 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(add5, 1'b0, 1'b0, 1'b1, 1'b0);
        step(add5f, 1'b0, 1'b0, 1'b0, 1'b1);
        step(ins(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SEL_REG), 1'b0, 1'b0, 1'b0, 1'b1);
        step(ins(5'd3, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SEL_REG), 1'b0, 1'b0, 1'b0, 1'b1);
        step(ins(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SEL_REG), 1'b0, 1'b0, 1'b0, 1'b1);
        step(ins(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_REG), 1'b0, 1'b0, 1'b0, 1'b1);
        step(lw9, 1'b0, 1'b0, 1'b0, 1'b1);
        step(ins(5'd9, 5'd4, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEL_REG), 1'b0, 1'b0, 1'b0, 1'b1);
        step(lw9, 1'b0, 1'b0, 1'b0, 1'b1);
        step(ins(5'd1, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_REG), 1'b0, 1'b0, 1'b1, 1'b0);
        step(ins(5'd1, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_MEM), 1'b0, 1'b0, 1'b0, 1'b1);
        step(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(add5, 1'b0, 1'b1, 1'b0, 1'b0);
        step(add5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(add5f, 1'b0, 1'b1, 1'b0, 1'b0);
        step(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(add5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(add5, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ID_EX_PERF_CNT_EN
        repeat (2) @(posedge CLK);
        #2;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        exp_sc = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            step(lw5, 1'b0, 1'b0, 1'b0, 1'b1);
            step(add5, 1'b0, 1'b0, 1'b1, 1'b0);
            step(add5f, 1'b0, 1'b0, 1'b0, 1'b1);
        end
`endif
        repeat (3) @(posedge CLK);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. It sits between decode and execute. Each cycle it captures decode-stage operands and controls, plus the ALU/data-memory forwarding selects produced in ID. It inserts a one-cycle bubble when a load in EX feeds an ALU operand of the instruction in ID, and it clears its contents on a branch/jump flush.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- CLK  in  1  core clock, all state on rising edge
- Reset  in  1  synchronous, active-high; loads bubble
- Flush  in  1  kill instruction in ID (taken branch/jump resolved in EX)
- ID_Rs, ID_Rt, ID_Rw  in  5 each  decode register indices
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, UseShamt, UseImmed  in  1 each  decode controls
- ID_ALUCtrl  in  4  ALU operation
- ID_BusA, ID_BusB, ID_Imm  in  32 each  register-file reads, sign/zero-extended immediate
- ID_Shamt  in  5  shift amount
- AluOpCtrlA, AluOpCtrlB  in  2 each  forwarding selects from the forwarding unit
- DataMemForwardCtrl_EX, DataMemForwardCtrl_MEM  in  1 each  store-data forwarding controls
- Stall  out  1  hold PC and IF/ID this cycle (combinational)
- EX_* outputs  out  same widths  registered copies of every ID_* input, AluOpCtrlA/B and DataMemForwardCtrl_EX/MEM
- StallCount, FlushCount  out  32 each  event counters (see Configuration)

## Operation
- Bubble value: all control bits 0, EX_Rw=0, EX_AluOpCtrlA/B=2'b11, DataMemForwardCtrl_* = 0, data fields 0.
- Load-use hazard (H):
  - Condition: EX_MemRead && EX_Rw!=0 && ((!UseShamt && ID_Rs==EX_Rw) || (!UseImmed && ID_Rt==EX_Rw)).
  - A store whose only dependency is store data (ID_Rt, UseImmed=1) does not raise H; DataMemForwardCtrl_MEM covers it.
- Stall = H && !Flush.
- Register update each edge, in priority order:
  - Reset → bubble.
  - Flush → bubble.
  - H → bubble; the ID instruction is held upstream and re-presented.
  - Otherwise capture all ID inputs.
- FSM:
  - States: RUN and BUBBLE; reset state RUN.
  - RUN→BUBBLE when a bubble is inserted because of H.
  - BUBBLE→RUN unconditionally next cycle.
  - In BUBBLE, Stall is forced to 0. This is consistent by construction, since the bubble clears EX_MemRead.
  - The FSM exists to expose the guarantee as an assertion point: at most one consecutive stall cycle per load.
- Flush during Stall: Flush wins, Stall=0, bubble loaded, FSM→RUN.
- Reset mid-stall: bubble, FSM→RUN, Stall=0 in the following cycle.

## Timing
- Latency: one cycle from ID inputs to EX_* outputs.
- Stall is combinational from the current ID inputs and registered EX state, valid in the same cycle. Upstream samples it at the same edge.
- Load-use costs exactly one cycle. In the cycle after the bubble, the load sits in MEM, and the forwarding unit selects the MEM path (01) for the re-presented instruction.
- Reset values: all EX_* = bubble, Stall=0, counters=0.

## Configuration
- ID_EX_PERF_CNT_EN defined:
  - StallCount increments on every cycle with Stall=1.
  - FlushCount increments on every edge where Flush=1 and Reset=0.
  - Both are 32-bit and saturate at 32'hFFFFFFFF; both clear on Reset.
- Undefined: StallCount and FlushCount are tied to 0 and no counter flops are built.

## Structure
- Shared package mips_pipe_pkg:
  - ALU select encodings: SEL_SHAMT_IMM=2'b00, SEL_MEM=2'b01, SEL_EX=2'b10, SEL_REG=2'b11.
  - FSM state enum.
  - Bubble constants.
- One combinational sub-module, load_use_detect. It computes H from the ID indices/uses and EX_Rw/EX_MemRead. It is reusable by the branch-compare stall logic.

## Test plan
- Reset: hold Reset=1 for 2 cycles with random ID inputs → all EX controls 0, EX_AluOpCtrlA/B=2'b11, Stall=0.
- Load-use on Rs: EX holds lw with EX_Rw=5, ID has add with ID_Rs=5, UseShamt=0 → Stall=1 for exactly one cycle, bubble in EX; next cycle the add is captured and EX_AluOpCtrlA=01 comes from the forwarding input.
- Store-data after load: EX lw with EX_Rw=7, ID sw with ID_Rt=7, ID_Rs=3, UseImmed=1 → Stall=0, EX_DataMemForwardCtrl_MEM=1 captured.
- $zero destination: EX lw with EX_Rw=0, ID_Rs=0 → Stall=0.
- Flush with hazard: hazard condition present and Flush=1 → Stall=0, bubble, no StallCount increment; FlushCount+1 when ID_EX_PERF_CNT_EN is defined.
- Counter saturation, macro defined: force StallCount to 32'hFFFFFFFE and trigger two load-use stalls → count holds 32'hFFFFFFFF.
